pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 61 ++++++
 rtl/sat_counter.sv | 31 +++
 rtl/pipe_stall_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// Holds the FSM state encoding, the counter and wait-counter widths, the
// default memory-wait limit, the control-bundle struct, and two small helpers:
// hazard detection and the RUN-priority resolution of branch versus load-use.
package pipe_ctrl_pkg;

  localparam int unsigned CNT_W          = 16;
  localparam int unsigned WAIT_W         = 8;
  localparam int unsigned REG_W          = 5;
  localparam int unsigned WAIT_LIMIT_DEF = 255;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ERROR   = 2'd2
  } state_e;

  // Per-cycle control bundle driven onto the pipeline registers.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic pipe_hold;
  } ctrl_t;

  // A load in EX writes a register that the instruction in ID reads.
  // Register 0 is hardwired, so a load to r0 never creates a dependency.
  function automatic logic load_use(input logic             memread,
                                    input logic [REG_W-1:0] ex_rt,
                                    input logic [REG_W-1:0] id_rs,
                                    input logic [REG_W-1:0] id_rt,
                                    input logic             uses_rt);
    return memread && (ex_rt != '0) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

  // Controls when the pipeline may advance: a taken branch squashes the
  // three younger stages (and makes any load-use stall moot), otherwise a
  // load-use hazard freezes PC/IF-ID and injects one bubble into EX.
  function automatic ctrl_t resolve_run(input logic branch,
                                        input logic hazard);
    ctrl_t c;
    c = '0;
    if (branch) begin
      c.pc_write     = 1'b1;
      c.if_id_write  = 1'b1;
      c.if_id_flush  = 1'b1;
      c.id_ex_flush  = 1'b1;
      c.ex_mem_flush = 1'b1;
    end else if (hazard) begin
      c.id_ex_flush  = 1'b1;
    end else begin
      c.pc_write     = 1'b1;
      c.if_id_write  = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the performance counters.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-high reset, clears the count
//   inc_i   - add one this cycle (ignored once at all-ones)
//   clr_i   - clear on the next edge, wins over inc_i
//   count_o - current count
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  // Hold at the top value instead of wrapping back to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != CNT_MAX)) begin
      count_o <= count_o + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall / flush controller for a classic 5-stage pipeline.
// Resolves, with zero latency, multi-cycle data-memory waits, taken
// branches and load-use hazards into PC / stage-register controls, and
// keeps saturating counts of stall cycles and branch flushes. A memory
// access that never completes within WAIT_LIMIT MEMWAIT cycles parks the
// controller in a sticky ERROR state left only through reset.
// Ports:
//   clk_i, rst_i                      - clock, synchronous active-high reset
//   id_ex_memread_i, id_ex_rt_i       - load in EX and its destination
//   if_id_rs_i, if_id_rt_i            - sources of the instruction in ID
//   if_id_uses_rt_i                   - ID instruction actually reads rt
//   branch_taken_i                    - branch in MEM resolved taken
//   mem_req_i, mem_ready_i            - MEM access pending / completing
//   cnt_clr_i                         - clear both performance counters
//   pc_write_o, if_id_write_o         - PC / IF-ID load enables
//   if_id_flush_o, id_ex_flush_o,
//   ex_mem_flush_o                    - bubble insertion per stage register
//   pipe_hold_o                       - freeze every pipeline register and PC
//   error_o                           - sticky memory-wait timeout
//   state_o                           - FSM state register
//   stall_cnt_o, flush_cnt_o          - saturating performance counters
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_ex_memread_i,
  input  logic [REG_W-1:0] id_ex_rt_i,
  input  logic [REG_W-1:0] if_id_rs_i,
  input  logic [REG_W-1:0] if_id_rt_i,
  input  logic             if_id_uses_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic             cnt_clr_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic             pipe_hold_o,
  output logic             error_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Last wait-count value tolerated before the timeout fires.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              hazard;
  logic              stall_inc;
  logic              flush_inc;
  ctrl_t             ctrl;

  assign hazard = load_use(id_ex_memread_i, id_ex_rt_i, if_id_rs_i,
                           if_id_rt_i, if_id_uses_rt_i);

  // State and wait-counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state plus zero-latency controls and counter increments.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    ctrl      = '0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    case (state_q)
      ST_RUN: begin
        // An outstanding memory access outranks branch and hazard handling.
        if (mem_req_i && !mem_ready_i) begin
          ctrl.pipe_hold = 1'b1;
          state_d        = ST_MEMWAIT;
        end else begin
          ctrl      = resolve_run(branch_taken_i, hazard);
          stall_inc = hazard && !branch_taken_i;
          flush_inc = branch_taken_i;
        end
        wait_d = '0;
      end

      ST_MEMWAIT: begin
        if (!mem_ready_i) begin
          ctrl.pipe_hold = 1'b1;
          wait_d         = wait_q + WAIT_W'(1);
          if (wait_q == WAIT_LAST) begin
            state_d = ST_ERROR;
          end
        end else begin
          // Memory completes: the pipe advances under normal RUN rules.
          ctrl      = resolve_run(branch_taken_i, hazard);
          stall_inc = hazard && !branch_taken_i;
          flush_inc = branch_taken_i;
          state_d   = ST_RUN;
          wait_d    = '0;
        end
      end

      ST_ERROR: begin
        ctrl.pipe_hold = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase

    if (ctrl.pipe_hold) begin
      stall_inc = 1'b1;
    end

    // Reset forces every control quiet regardless of the current state.
    if (rst_i) begin
      ctrl      = '0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end
  end

  assign pc_write_o     = ctrl.pc_write;
  assign if_id_write_o  = ctrl.if_id_write;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_flush_o  = ctrl.id_ex_flush;
  assign ex_mem_flush_o = ctrl.ex_mem_flush;
  assign pipe_hold_o    = ctrl.pipe_hold;
  assign error_o        = (state_q == ST_ERROR) && !rst_i;
  assign state_o        = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (stall_inc),
    .clr_i   (cnt_clr_i),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (flush_inc),
    .clr_i   (cnt_clr_i),
    .count_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl (WAIT_LIMIT = 4).
// Stimulus pushes the hand-computed controls/state for each cycle plus the
// counter values tracked by a small saturating model; a negedge monitor
// pops one entry per cycle and compares it with the DUT outputs.
module tb_pipe_stall_ctrl;

  // Control vector order: pc_write, if_id_write, if_id_flush, id_ex_flush,
  // ex_mem_flush, pipe_hold, error.
  localparam logic [6:0] C_RUN  = 7'b1100000;
  localparam logic [6:0] C_HOLD = 7'b0000010;
  localparam logic [6:0] C_BR   = 7'b1111100;
  localparam logic [6:0] C_LU   = 7'b0001000;
  localparam logic [6:0] C_ERR  = 7'b0000011;
  localparam logic [6:0] C_RST  = 7'b0000000;
  localparam logic [1:0] S_SKIP = 2'd3;

  typedef struct packed {
    logic [15:0] tag;
    logic [6:0]  ctrl;
    logic [1:0]  st;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  logic        clk;
  logic        rst_i;
  logic        id_ex_memread_i;
  logic [4:0]  id_ex_rt_i;
  logic [4:0]  if_id_rs_i;
  logic [4:0]  if_id_rt_i;
  logic        if_id_uses_rt_i;
  logic        branch_taken_i;
  logic        mem_req_i;
  logic        mem_ready_i;
  logic        cnt_clr_i;
  logic        pc_write_o;
  logic        if_id_write_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic        ex_mem_flush_o;
  logic        pipe_hold_o;
  logic        error_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          vec_id   = 0;
  logic [15:0] m_stall  = '0;
  logic [15:0] m_flush  = '0;

  pipe_stall_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .id_ex_memread_i (id_ex_memread_i),
    .id_ex_rt_i      (id_ex_rt_i),
    .if_id_rs_i      (if_id_rs_i),
    .if_id_rt_i      (if_id_rt_i),
    .if_id_uses_rt_i (if_id_uses_rt_i),
    .branch_taken_i  (branch_taken_i),
    .mem_req_i       (mem_req_i),
    .mem_ready_i     (mem_ready_i),
    .cnt_clr_i       (cnt_clr_i),
    .pc_write_o      (pc_write_o),
    .if_id_write_o   (if_id_write_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_flush_o   (id_ex_flush_o),
    .ex_mem_flush_o  (ex_mem_flush_o),
    .pipe_hold_o     (pipe_hold_o),
    .error_o         (error_o),
    .state_o         (state_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int tag,
                     input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  // Monitor: one expected entry is due per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("ctrl", int'(mon_e.tag),
          16'({pc_write_o, if_id_write_o, if_id_flush_o, id_ex_flush_o,
               ex_mem_flush_o, pipe_hold_o, error_o}), 16'(mon_e.ctrl));
      if (mon_e.st != S_SKIP)
        chk("state", int'(mon_e.tag), 16'(state_o), 16'(mon_e.st));
      chk("stall_cnt", int'(mon_e.tag), stall_cnt_o, mon_e.stall);
      chk("flush_cnt", int'(mon_e.tag), flush_cnt_o, mon_e.flush);
    end
  end

  task automatic set_in(input logic mr, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic br,
                        input logic req, input logic rdy);
    id_ex_memread_i = mr;
    id_ex_rt_i      = ert;
    if_id_rs_i      = rs;
    if_id_rt_i      = rt;
    if_id_uses_rt_i = urt;
    branch_taken_i  = br;
    mem_req_i       = req;
    mem_ready_i     = rdy;
  endtask

  // One clock cycle: optionally queue the expectation, then advance the
  // counter model by what the expected controls imply for this cycle.
  task automatic cyc(input logic [6:0] ectrl, input logic [1:0] est,
                     input logic push);
    if (push) begin
      vec_id++;
      sb.push_back('{tag: 16'(vec_id), ctrl: ectrl, st: est,
                     stall: m_stall, flush: m_flush});
    end
    if (rst_i || cnt_clr_i) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if ((ectrl[1] || ectrl == C_LU) && m_stall != 16'hFFFF) m_stall++;
      if (ectrl == C_BR && m_flush != 16'hFFFF) m_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i     = 1'b1;
    cnt_clr_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc(C_RST, 2'd0, 1);                      // reset held: all quiet
    rst_i = 1'b0;

    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc(C_RUN, 2'd0, 1);
    // Load-use on rs
    set_in(1, 5, 5, 0, 0, 0, 0, 0); cyc(C_LU, 2'd0, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc(C_RUN, 2'd0, 1);   // stall_cnt 1
    // Load-use on rt, only when rt is read
    set_in(1, 7, 3, 7, 1, 0, 0, 0); cyc(C_LU, 2'd0, 1);
    set_in(1, 7, 3, 7, 0, 0, 0, 0); cyc(C_RUN, 2'd0, 1);
    // r0 destination and non-load never stall
    set_in(1, 0, 0, 0, 1, 0, 0, 0); cyc(C_RUN, 2'd0, 1);
    set_in(0, 5, 5, 5, 1, 0, 0, 0); cyc(C_RUN, 2'd0, 1);
    // Branch beats load-use
    set_in(1, 5, 5, 0, 0, 1, 0, 0); cyc(C_BR, 2'd0, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc(C_RUN, 2'd0, 1);   // flush 1, stall 2
    // Memory request completing at once: no hold
    set_in(0, 0, 0, 0, 0, 0, 1, 1); cyc(C_RUN, 2'd0, 1);
    // Three-cycle memory wait
    set_in(0, 0, 0, 0, 0, 0, 1, 0); cyc(C_HOLD, 2'd0, 1);
    cyc(C_HOLD, 2'd1, 1);
    cyc(C_HOLD, 2'd1, 1);
    set_in(0, 0, 0, 0, 0, 0, 1, 1); cyc(C_RUN, 2'd1, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc(C_RUN, 2'd0, 1);
    // Memory wait beats branch; release cycle with branch / hazard
    set_in(0, 0, 0, 0, 0, 1, 1, 0); cyc(C_HOLD, 2'd0, 1);
    set_in(0, 0, 0, 0, 0, 1, 1, 1); cyc(C_BR, 2'd1, 1);
    set_in(0, 0, 0, 0, 0, 0, 1, 0); cyc(C_HOLD, 2'd0, 1);
    set_in(1, 9, 2, 9, 1, 0, 1, 1); cyc(C_LU, 2'd1, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc(C_RUN, 2'd0, 1);
    // Counter clear
    cnt_clr_i = 1'b1; cyc(C_RUN, 2'd0, 1);
    cnt_clr_i = 1'b0; cyc(C_RUN, 2'd0, 1);
    // Timeout: one RUN hold, four MEMWAIT cycles, then sticky ERROR
    set_in(0, 0, 0, 0, 0, 0, 1, 0); cyc(C_HOLD, 2'd0, 1);
    for (int i = 0; i < 4; i++) cyc(C_HOLD, 2'd1, 1);
    cyc(C_ERR, 2'd2, 1);
    set_in(0, 0, 0, 0, 0, 1, 0, 1); cyc(C_ERR, 2'd2, 1);
    cyc(C_ERR, 2'd2, 1);
    rst_i = 1'b1;
    cyc(C_RST, S_SKIP, 1);
    cyc(C_RST, 2'd0, 1);
    rst_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc(C_RUN, 2'd0, 1);
    // Flush counter saturation and clear
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 65535; i++) cyc(C_BR, 2'd0, 0);
    cyc(C_BR, 2'd0, 1);
    cyc(C_BR, 2'd0, 1);
    cnt_clr_i = 1'b1; cyc(C_BR, 2'd0, 1);
    cnt_clr_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc(C_RUN, 2'd0, 1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
